// File: rtl/mis_stimulus_gen.sv
// Stimulus source for multiple-input-switching delay experiments on a two-input NOR chain.
// Drives A1/A2 with cycle-exact skewed edges, repeated for a programmable number of trials.
module mis_stimulus_gen #(
  parameter int CNT_W   = 8,
  parameter int REP_W   = 8,
  parameter int GAP_CYC = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             polarity,
  input  logic [CNT_W-1:0] delay_a,
  input  logic [CNT_W-1:0] delay_b,
  input  logic [CNT_W-1:0] hold_len,
  input  logic [REP_W-1:0] num_reps,
  output logic             stim_a1,
  output logic             stim_a2,
  output logic             busy,
  output logic             done,
  output logic [REP_W-1:0] rep_cnt
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             pol_q, pol_d;
  logic [CNT_W-1:0] da_q, da_d;
  logic [CNT_W-1:0] db_q, db_d;
  logic [CNT_W:0]   t_end_q, t_end_d;
  logic [CNT_W:0]   t_q, t_d;
  logic [REP_W-1:0] reps_q, reps_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             a1_q, a1_d;
  logic             a2_q, a2_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] max_delay;
  logic [CNT_W-1:0] hold_eff;
  logic             idle_lvl;

  // Next-state, datapath and output computation for the trial sequencer
  always_comb begin
    state_d  = state_q;
    pol_d    = pol_q;
    da_d     = da_q;
    db_d     = db_q;
    t_end_d  = t_end_q;
    t_d      = t_q;
    reps_d   = reps_q;
    rep_d    = rep_q;
    gap_d    = gap_q;
    a1_d     = a1_q;
    a2_d     = a2_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    idle_lvl = ~pol_q;

    max_delay = (delay_a > delay_b) ? delay_a : delay_b;
    hold_eff  = (hold_len == {CNT_W{1'b0}}) ? CNT_W'(1) : hold_len;

    case (state_q)
      S_IDLE: begin
        a1_d = idle_lvl;
        a2_d = idle_lvl;
        if (start) begin
          // The new run's idle level applies from the acceptance edge onward
          pol_d   = polarity;
          da_d    = delay_a;
          db_d    = delay_b;
          t_end_d = {1'b0, max_delay} + {1'b0, hold_eff};
          reps_d  = num_reps;
          rep_d   = {REP_W{1'b0}};
          t_d     = {(CNT_W+1){1'b0}};
          busy_d  = 1'b1;
          a1_d    = ~polarity;
          a2_d    = ~polarity;
          if (num_reps != {REP_W{1'b0}}) begin
            state_d = S_RUN;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          a1_d    = idle_lvl;
          a2_d    = idle_lvl;
          busy_d  = 1'b0;
        end else if (t_q == t_end_q) begin
          state_d = S_GAP;
          a1_d    = idle_lvl;
          a2_d    = idle_lvl;
          gap_d   = {GAP_W{1'b0}};
          rep_d   = (rep_q < reps_q) ? (rep_q + REP_W'(1)) : rep_q;
        end else begin
          a1_d = (t_q >= {1'b0, da_q}) ? pol_q : idle_lvl;
          a2_d = (t_q >= {1'b0, db_q}) ? pol_q : idle_lvl;
          t_d  = t_q + (CNT_W+1)'(1);
        end
      end
      S_GAP: begin
        a1_d = idle_lvl;
        a2_d = idle_lvl;
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (gap_q == GAP_LAST) begin
          if (rep_q < reps_q) begin
            state_d = S_RUN;
            t_d     = {(CNT_W+1){1'b0}};
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        a1_d    = idle_lvl;
        a2_d    = idle_lvl;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        a1_d    = idle_lvl;
        a2_d    = idle_lvl;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and configuration registers; outputs are taken straight from these flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pol_q   <= 1'b1;
      da_q    <= {CNT_W{1'b0}};
      db_q    <= {CNT_W{1'b0}};
      t_end_q <= {(CNT_W+1){1'b0}};
      t_q     <= {(CNT_W+1){1'b0}};
      reps_q  <= {REP_W{1'b0}};
      rep_q   <= {REP_W{1'b0}};
      gap_q   <= {GAP_W{1'b0}};
      a1_q    <= 1'b0;
      a2_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pol_q   <= pol_d;
      da_q    <= da_d;
      db_q    <= db_d;
      t_end_q <= t_end_d;
      t_q     <= t_d;
      reps_q  <= reps_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign stim_a1 = a1_q;
  assign stim_a2 = a2_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rep_cnt = rep_q;

endmodule

// File: tb/tb_mis_stimulus_gen.sv
// Self-checking bench for mis_stimulus_gen: directed scenarios plus randomized runs,
// each cycle compared against an arithmetic trial-schedule model.
module tb_mis_stimulus_gen;

  localparam int GAP = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       polarity;
  logic [7:0] delay_a;
  logic [7:0] delay_b;
  logic [7:0] hold_len;
  logic [7:0] num_reps;
  logic       stim_a1;
  logic       stim_a2;
  logic       busy;
  logic       done;
  logic [7:0] rep_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  // Configuration of the run currently being modelled
  int m_pol;
  int m_da;
  int m_db;
  int m_hold;
  int m_reps;

  mis_stimulus_gen #(
    .CNT_W  (8),
    .REP_W  (8),
    .GAP_CYC(GAP)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .polarity(polarity),
    .delay_a (delay_a),
    .delay_b (delay_b),
    .hold_len(hold_len),
    .num_reps(num_reps),
    .stim_a1 (stim_a1),
    .stim_a2 (stim_a2),
    .busy    (busy),
    .done    (done),
    .rep_cnt (rep_cnt)
  );

  always #5 clk = ~clk;

  function automatic int trial_len(input int da, input int db, input int hold);
    return ((da > db) ? da : db) + ((hold == 0) ? 1 : hold);
  endfunction

  // Expected {a1, a2, busy, done, rep_cnt} just after edge E(k) of an unaborted run
  function automatic logic [11:0] base_at(input int k);
    int tl, p, j, rel, rep;
    logic act, idl, a1, a2, b, d;
    tl  = trial_len(m_da, m_db, m_hold);
    p   = tl + 1 + GAP;
    act = (m_pol != 0);
    idl = ~act;
    if (k >= m_reps * p) begin
      a1  = idl;
      a2  = idl;
      b   = (k == m_reps * p);
      d   = b;
      rep = m_reps;
    end else begin
      j   = k / p;
      rel = k % p;
      a1  = (rel > m_da && rel <= tl) ? act : idl;
      a2  = (rel > m_db && rel <= tl) ? act : idl;
      b   = 1'b1;
      d   = 1'b0;
      rep = j + ((rel > tl) ? 1 : 0);
    end
    return {a1, a2, b, d, 8'(rep)};
  endfunction

  function automatic logic [11:0] expect_at(input int k, input int abort_k);
    logic [11:0] v;
    logic [11:0] pre;
    logic        idl;
    v   = base_at(k);
    idl = (m_pol == 0);
    if (abort_k >= 1 && k >= abort_k) begin
      pre = base_at(abort_k - 1);
      v   = {idl, idl, 1'b0, 1'b0, pre[7:0]};
    end
    return v;
  endfunction

  task automatic check(input string tag, input int k, input logic [11:0] exp);
    logic [11:0] obs;
    obs = {stim_a1, stim_a2, busy, done, rep_cnt};
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s k=%0d: observed {a1,a2,busy,done,rep}=%b_%b_%b_%b_%0d required %b_%b_%b_%b_%0d",
             tag, k, obs[11], obs[10], obs[9], obs[8], obs[7:0],
             exp[11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  // One run: start at E0, then check every cycle while scrambling inputs the DUT must ignore
  task automatic run(input string tag, input int pol, input int da, input int db,
                     input int hold, input int reps, input int abort_k, input bit abort_at_start);
    int endk;
    m_pol    = pol;
    m_da     = da;
    m_db     = db;
    m_hold   = hold;
    m_reps   = reps;
    polarity = 1'(pol);
    delay_a  = 8'(da);
    delay_b  = 8'(db);
    hold_len = 8'(hold);
    num_reps = 8'(reps);
    start    = 1'b1;
    abort    = abort_at_start;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    endk  = (abort_k >= 1) ? abort_k : reps * (trial_len(da, db, hold) + 1 + GAP) + 1;
    for (int k = 0; k <= endk + 2; k++) begin
      check(tag, k, expect_at(k, abort_k));
      if (k + 1 <= endk) begin
        start    = 1'($urandom);
        polarity = 1'($urandom);
        delay_a  = 8'($urandom);
        delay_b  = 8'($urandom);
        hold_len = 8'($urandom);
        num_reps = 8'($urandom);
        abort    = (k + 1 == abort_k);
      end else begin
        start = 1'b0;
        abort = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int rp, rda, rdb, rh, rr, rak, p;
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    polarity = 1'b0;
    delay_a  = 8'd0;
    delay_b  = 8'd0;
    hold_len = 8'd0;
    num_reps = 8'd0;
    #12;
    check("reset", -1, 12'h000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_idle", -1, 12'h000);

    run("basic",        1, 2, 5, 3, 1, -1, 1'b0);
    run("simultaneous", 0, 4, 4, 2, 3, -1, 1'b0);
    run("a2_leads",     1, 7, 0, 0, 1, -1, 1'b0);
    run("zero_reps",    1, 3, 3, 1, 0, -1, 1'b0);
    run("abort_hold",   1, 2, 5, 3, 5, 32, 1'b0);
    run("start_wins",   1, 1, 3, 2, 2, -1, 1'b1);

    // Asynchronous reset in the middle of a falling-polarity trial
    m_pol    = 0;
    m_da     = 3;
    m_db     = 3;
    m_hold   = 2;
    m_reps   = 2;
    polarity = 1'b0;
    delay_a  = 8'd3;
    delay_b  = 8'd3;
    hold_len = 8'd2;
    num_reps = 8'd2;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("rst_pre", 0, expect_at(0, -1));
    @(posedge clk); #1;
    check("rst_pre", 1, expect_at(1, -1));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 1, 12'h000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_rst", 0, 12'h000);

    for (int i = 0; i < 8; i++) begin
      rp  = int'($urandom_range(0, 1));
      rda = int'($urandom_range(0, 12));
      rdb = int'($urandom_range(0, 12));
      rh  = int'($urandom_range(0, 5));
      rr  = int'($urandom_range(1, 3));
      p   = trial_len(rda, rdb, rh) + 1 + GAP;
      rak = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, rr * p)) : -1;
      run("random", rp, rda, rdb, rh, rr, rak, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
